// File: rtl/tx_queue_fetch_pkg.sv
// Shared definitions for the tx queue fetch stage.
//   fetch_state_e : FSM state encoding
//   QUEUE_NONE    : tx_queue_idx value meaning "no queue selected"
//   RR_RESET      : round-robin pointer reset value (queue 0 wins first)
//   CTS_MSB/LSB   : cts_toself_config field inside the descriptor word
//   rr_next()     : cyclic successor in the order 0,1,2
package tx_queue_fetch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StMeta,
        StWaitTsf,
        StStart,
        StStream,
        StDone
    } fetch_state_e;

    localparam logic [1:0] QUEUE_NONE = 2'd3;
    localparam logic [1:0] RR_RESET   = 2'd2;

    localparam int unsigned CTS_MSB = 63;
    localparam int unsigned CTS_LSB = 32;

    function automatic logic [1:0] rr_next(input logic [1:0] q);
        return (q >= 2'd2) ? 2'd0 : q + 2'd1;
    endfunction

endpackage

// File: rtl/tx_queue_fetch_if.sv
// Bundle of the queue-side FIFO signals and the bit-interface stream.
//   master : the fetch block (drives asks, queue select, packet info, stream)
//   slave  : the environment (FIFOs, TSF timer, downstream consumer)
interface tx_queue_fetch_if #(
    parameter int unsigned C_S_AXIS_TDATA_WIDTH   = 64,
    parameter int unsigned TSF_TIMER_WIDTH        = 64,
    parameter int unsigned MAX_BIT_NUM_DMA_SYMBOL = 14
);
    logic [2:0]                          queue_enable;
    logic                                empty_to_acc_0;
    logic                                empty_to_acc_1;
    logic                                empty_to_acc_2;
    logic                                emptyn_to_acc;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]     dmg_to_acc;
    logic [TSF_TIMER_WIDTH-1:0]          tsf_to_acc;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]     data_to_acc;
    logic [TSF_TIMER_WIDTH-1:0]          tsf_runtime_val;
    logic [1:0]                          tx_queue_idx;
    logic                                acc_ask_dmg;
    logic                                acc_ask_tsf;
    logic                                acc_ask_data;
    logic                                pkt_start;
    logic [31:0]                         pkt_cts_config;
    logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   pkt_num_word;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]     m_data;
    logic                                m_valid;
    logic                                m_ready;
    logic                                m_last;
    logic                                pkt_done;
    logic                                err_stall;

    modport master (
        input  queue_enable, empty_to_acc_0, empty_to_acc_1, empty_to_acc_2, emptyn_to_acc,
        input  dmg_to_acc, tsf_to_acc, data_to_acc, tsf_runtime_val, m_ready,
        output tx_queue_idx, acc_ask_dmg, acc_ask_tsf, acc_ask_data, pkt_start,
        output pkt_cts_config, pkt_num_word, m_data, m_valid, m_last, pkt_done, err_stall
    );

    modport slave (
        output queue_enable, empty_to_acc_0, empty_to_acc_1, empty_to_acc_2, emptyn_to_acc,
        output dmg_to_acc, tsf_to_acc, data_to_acc, tsf_runtime_val, m_ready,
        input  tx_queue_idx, acc_ask_dmg, acc_ask_tsf, acc_ask_data, pkt_start,
        input  pkt_cts_config, pkt_num_word, m_data, m_valid, m_last, pkt_done, err_stall
    );

endinterface

// File: rtl/tx_queue_rr_arb.sv
// Combinational 3-way round-robin arbiter.
//   req_i   : request per queue
//   last_i  : queue granted last time (search starts just after it)
//   gnt_o   : granted queue index (QUEUE_NONE when nothing requests)
//   valid_o : a grant was made
module tx_queue_rr_arb
    import tx_queue_fetch_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] last_i,
    output logic [1:0] gnt_o,
    output logic       valid_o
);

    logic [3:0] req_ext;
    logic [1:0] c1, c2, c3;

    assign req_ext = {1'b0, req_i};
    assign c1      = rr_next(last_i);
    assign c2      = rr_next(c1);
    assign c3      = rr_next(c2);

    always_comb begin
        gnt_o   = QUEUE_NONE;
        valid_o = 1'b0;
        if (req_ext[c1]) begin
            gnt_o   = c1;
            valid_o = 1'b1;
        end else if (req_ext[c2]) begin
            gnt_o   = c2;
            valid_o = 1'b1;
        end else if (req_ext[c3]) begin
            gnt_o   = c3;
            valid_o = 1'b1;
        end
    end

endmodule

// File: rtl/tx_queue_fetch.sv
// Tx queue fetch: picks a queue holding a complete descriptor (round-robin),
// pops descriptor + TSF words, waits for the TSF target time, then streams the
// packet's data words downstream over valid/ready.
//   clk, rstn : clock, asynchronous active-low reset
//   bus_io    : queue FIFO heads/pops, TSF timer, packet info and data stream
module tx_queue_fetch #(
    parameter int unsigned TSF_TIMER_WIDTH        = 64,
    parameter int unsigned MAX_BIT_NUM_DMA_SYMBOL = 14,
    parameter int unsigned STALL_LIMIT            = 255
) (
    input logic              clk,
    input logic              rstn,
    tx_queue_fetch_if.master bus_io
);
    import tx_queue_fetch_pkg::*;

    localparam int unsigned NW     = MAX_BIT_NUM_DMA_SYMBOL;
    localparam int unsigned StallW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT + 1) : 1;

    fetch_state_e               state_q, state_d;
    logic [1:0]                 idx_q, idx_d;
    logic [1:0]                 rr_q, rr_d;
    logic [31:0]                cts_q, cts_d;
    logic [NW-1:0]              num_q, num_d;
    logic [NW-1:0]              rem_q, rem_d;
    logic [TSF_TIMER_WIDTH-1:0] tgt_q, tgt_d;
    logic [StallW-1:0]          stall_q, stall_d;

    logic [2:0] req;
    logic [1:0] gnt;
    logic       gnt_valid;
    logic       hs;
    logic       unused_dmg;

    // Descriptor bits between the word count and the cts field carry nothing here.
    assign unused_dmg = ^bus_io.dmg_to_acc[CTS_LSB-1:NW];

    assign req = bus_io.queue_enable &
                 {~bus_io.empty_to_acc_2, ~bus_io.empty_to_acc_1, ~bus_io.empty_to_acc_0};

    tx_queue_rr_arb u_arb (
        .req_i   (req),
        .last_i  (rr_q),
        .gnt_o   (gnt),
        .valid_o (gnt_valid)
    );

    assign bus_io.tx_queue_idx   = idx_q;
    assign bus_io.pkt_cts_config = cts_q;
    assign bus_io.pkt_num_word   = num_q;
    assign bus_io.m_data         = bus_io.data_to_acc;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        cts_d   = cts_q;
        num_d   = num_q;
        rem_d   = rem_q;
        tgt_d   = tgt_q;
        stall_d = stall_q;
        hs      = 1'b0;

        bus_io.acc_ask_dmg  = 1'b0;
        bus_io.acc_ask_tsf  = 1'b0;
        bus_io.acc_ask_data = 1'b0;
        bus_io.pkt_start    = 1'b0;
        bus_io.pkt_done     = 1'b0;
        bus_io.m_valid      = 1'b0;
        bus_io.m_last       = 1'b0;
        bus_io.err_stall    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    idx_d   = gnt;
                    rr_d    = gnt;
                    state_d = StSettle;
                end
            end
            // Upstream muxes by tx_queue_idx; give the head words a cycle to settle.
            StSettle: state_d = StMeta;
            StMeta: begin
                cts_d               = bus_io.dmg_to_acc[CTS_MSB:CTS_LSB];
                num_d               = bus_io.dmg_to_acc[NW-1:0];
                tgt_d               = bus_io.tsf_to_acc;
                bus_io.acc_ask_dmg  = 1'b1;
                bus_io.acc_ask_tsf  = 1'b1;
                state_d             = StWaitTsf;
            end
            StWaitTsf: begin
                if (tgt_q == '0 || bus_io.tsf_runtime_val >= tgt_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                bus_io.pkt_start = 1'b1;
                rem_d            = num_q;
                stall_d          = '0;
                if (num_q == '0) begin
                    // Empty packet: descriptor consumed, nothing to stream.
                    bus_io.pkt_done = 1'b1;
                    idx_d           = QUEUE_NONE;
                    state_d         = StIdle;
                end else begin
                    state_d = StStream;
                end
            end
            StStream: begin
                bus_io.m_valid      = bus_io.emptyn_to_acc;
                bus_io.m_last       = bus_io.emptyn_to_acc && (rem_q == NW'(1));
                hs                  = bus_io.emptyn_to_acc && bus_io.m_ready;
                bus_io.acc_ask_data = hs;
                if (hs) begin
                    rem_d   = rem_q - NW'(1);
                    stall_d = '0;
                    if (rem_q == NW'(1)) begin
                        state_d = StDone;
                    end
                end else if (!bus_io.emptyn_to_acc) begin
                    // Saturating count gives one err_stall per starvation episode.
                    if (stall_q != StallW'(STALL_LIMIT)) begin
                        stall_d = stall_q + StallW'(1);
                    end
                    bus_io.err_stall = (stall_q == StallW'(STALL_LIMIT - 1));
                end
            end
            StDone: begin
                bus_io.pkt_done = 1'b1;
                idx_d           = QUEUE_NONE;
                state_d         = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            idx_q   <= QUEUE_NONE;
            rr_q    <= RR_RESET;
            cts_q   <= '0;
            num_q   <= '0;
            rem_q   <= '0;
            tgt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            cts_q   <= cts_d;
            num_q   <= num_d;
            rem_q   <= rem_d;
            tgt_q   <= tgt_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_tx_queue_fetch.sv
// Bench for tx_queue_fetch: FWFT queue models feed the DUT; expected packet
// headers and data words are queued as stimulus is issued and a negedge
// monitor pops and compares them whenever the DUT starts a packet or
// completes a data handshake.
module tb_tx_queue_fetch;
    import tx_queue_fetch_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    tx_queue_fetch_if bus_if ();

    tx_queue_fetch #(
        .TSF_TIMER_WIDTH        (64),
        .MAX_BIT_NUM_DMA_SYMBOL (14),
        .STALL_LIMIT            (255)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus_io (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Upstream FIFO models (write side owned by the main process).
    logic [63:0] desc_mem [3][64];
    logic [63:0] tsf_mem  [3][64];
    logic [63:0] dat_mem  [3][64];
    int dwr [3];
    int xwr [3];
    int drd [3];
    int trd [3];
    int xrd [3];
    int sel_q;
    logic starve = 1'b0;

    logic [95:0] exp_hdr [$];
    logic [95:0] exp_word[$];

    // Event counters and cycle stamps.
    int cyc, n_dmg, n_tsf, n_data, n_start, n_done, n_stall, n_both, n_sel1;
    int sel_cyc, ask_cyc, start_cyc, t1000_cyc;

    always_comb begin
        sel_q                 = int'(bus_if.tx_queue_idx);
        bus_if.empty_to_acc_0 = (drd[0] == dwr[0]);
        bus_if.empty_to_acc_1 = (drd[1] == dwr[1]);
        bus_if.empty_to_acc_2 = (drd[2] == dwr[2]);
        bus_if.emptyn_to_acc  = 1'b0;
        bus_if.dmg_to_acc     = '0;
        bus_if.tsf_to_acc     = '0;
        bus_if.data_to_acc    = '0;
        if (sel_q < 3) begin
            bus_if.dmg_to_acc    = desc_mem[sel_q][drd[sel_q]];
            bus_if.tsf_to_acc    = tsf_mem[sel_q][trd[sel_q]];
            bus_if.data_to_acc   = dat_mem[sel_q][xrd[sel_q]];
            bus_if.emptyn_to_acc = !starve && (xrd[sel_q] < xwr[sel_q]);
        end
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int q = 0; q < 3; q++) begin
                drd[q] <= 0;
                trd[q] <= 0;
                xrd[q] <= 0;
            end
        end else if (sel_q < 3) begin
            if (bus_if.acc_ask_dmg)  drd[sel_q] <= drd[sel_q] + 1;
            if (bus_if.acc_ask_tsf)  trd[sel_q] <= trd[sel_q] + 1;
            if (bus_if.acc_ask_data) xrd[sel_q] <= xrd[sel_q] + 1;
        end
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc <= 0; n_dmg <= 0; n_tsf <= 0; n_data <= 0; n_start <= 0; n_done <= 0;
            n_stall <= 0; n_both <= 0; n_sel1 <= 0;
            sel_cyc <= -1; ask_cyc <= -1; start_cyc <= -1; t1000_cyc <= -1;
        end else begin
            cyc <= cyc + 1;
            if (bus_if.acc_ask_dmg) begin
                n_dmg   <= n_dmg + 1;
                ask_cyc <= cyc;
            end
            if (bus_if.acc_ask_tsf)  n_tsf <= n_tsf + 1;
            if (bus_if.acc_ask_data) n_data <= n_data + 1;
            if (bus_if.pkt_start) begin
                n_start   <= n_start + 1;
                start_cyc <= cyc;
            end
            if (bus_if.pkt_done)                     n_done <= n_done + 1;
            if (bus_if.pkt_start && bus_if.pkt_done) n_both <= n_both + 1;
            if (bus_if.err_stall)                    n_stall <= n_stall + 1;
            if (bus_if.tx_queue_idx == 2'd1)         n_sel1 <= n_sel1 + 1;
            if (sel_cyc < 0 && bus_if.tx_queue_idx != QUEUE_NONE) sel_cyc <= cyc;
            if (t1000_cyc < 0 && bus_if.tsf_runtime_val == 64'd1000) t1000_cyc <= cyc;
        end
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare against the scoreboard whenever the DUT presents output.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus_if.pkt_start) begin
                if (exp_hdr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pkt_start actual=%0d required=none",
                             bus_if.tx_queue_idx);
                end else begin
                    check("pkt_hdr", {bus_if.tx_queue_idx, bus_if.pkt_cts_config,
                                      bus_if.pkt_num_word}, exp_hdr.pop_front());
                end
            end
            if (bus_if.m_valid && bus_if.m_ready) begin
                if (exp_word.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none", bus_if.m_data);
                end else begin
                    check("data_word", {bus_if.m_last, bus_if.m_data}, exp_word.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        rstn                   = 1'b0;
        starve                 = 1'b0;
        bus_if.m_ready         = 1'b1;
        bus_if.queue_enable    = 3'b111;
        bus_if.tsf_runtime_val = '0;
        for (int q = 0; q < 3; q++) begin
            dwr[q] = 0;
            xwr[q] = 0;
        end
        exp_hdr.delete();
        exp_word.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic load_pkt(input int q, input logic [31:0] cts, input int n,
                            input logic [63:0] tsf, input logic [63:0] base);
        desc_mem[q][dwr[q]] = {cts, 32'(n)};
        tsf_mem[q][dwr[q]]  = tsf;
        for (int i = 0; i < n; i++) begin
            dat_mem[q][xwr[q]] = base + 64'(i);
            xwr[q]++;
        end
        dwr[q]++;
    endtask

    task automatic expect_pkt(input int q, input logic [31:0] cts, input int n,
                              input logic [63:0] base, input bit with_words);
        exp_hdr.push_back({48'd0, 2'(q), cts, 14'(n)});
        if (with_words) begin
            for (int i = 0; i < n; i++) exp_word.push_back({31'd0, i == n - 1, base + 64'(i)});
        end
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int c = 0;
        while (n_done < n && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check({name, "_done"}, 96'(n_done), 96'(n));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_sb_empty(input string name);
        check({name, "_hdr_left"}, 96'(exp_hdr.size()), 96'd0);
        check({name, "_word_left"}, 96'(exp_word.size()), 96'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state.
        do_reset();
        #1;
        check("rst_idx", 96'(bus_if.tx_queue_idx), 96'd3);
        check("rst_ctl", {bus_if.acc_ask_dmg, bus_if.acc_ask_tsf, bus_if.acc_ask_data,
                          bus_if.pkt_start, bus_if.pkt_done, bus_if.m_valid, bus_if.m_last,
                          bus_if.err_stall}, 96'd0);
        check("rst_info", {bus_if.pkt_cts_config, bus_if.pkt_num_word}, 96'd0);

        // Queue 1 only, N=3, TSF=0.
        load_pkt(1, 32'h0000_0001, 3, 64'd0, 64'h1100);
        expect_pkt(1, 32'h0000_0001, 3, 64'h1100, 1'b1);
        wait_done(1, 100, "t1");
        // Select decided in IDLE, index visible in SETTLE, asks in META.
        check("t1_ask_after_sel", 96'(ask_cyc - sel_cyc), 96'd1);
        check("t1_n_dmg", 96'(n_dmg), 96'd1);
        check("t1_n_tsf", 96'(n_tsf), 96'd1);
        check("t1_n_data", 96'(n_data), 96'd3);
        check("t1_idx_back", 96'(bus_if.tx_queue_idx), 96'd3);
        check_sb_empty("t1");

        // All queues hold two packets: order 0,1,2,0,1,2.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int q = 0; q < 3; q++) begin
                load_pkt(q, 32'(32'hC0 + q * 16 + p), 2, 64'd0, 64'((q << 12) | (p << 8)));
            end
        end
        for (int p = 0; p < 2; p++) begin
            for (int q = 0; q < 3; q++) begin
                expect_pkt(q, 32'(32'hC0 + q * 16 + p), 2, 64'((q << 12) | (p << 8)), 1'b1);
            end
        end
        wait_done(6, 300, "t2");
        check("t2_n_data", 96'(n_data), 96'd12);
        check_sb_empty("t2");

        // queue_enable=101: queue 1 never served.
        do_reset();
        bus_if.queue_enable = 3'b101;
        load_pkt(0, 32'hA0, 1, 64'd0, 64'h100);
        load_pkt(1, 32'hA1, 1, 64'd0, 64'h200);
        load_pkt(2, 32'hA2, 1, 64'd0, 64'h300);
        load_pkt(0, 32'hA3, 1, 64'd0, 64'h400);
        expect_pkt(0, 32'hA0, 1, 64'h100, 1'b1);
        expect_pkt(2, 32'hA2, 1, 64'h300, 1'b1);
        expect_pkt(0, 32'hA3, 1, 64'h400, 1'b1);
        wait_done(3, 200, "t3");
        repeat (20) @(posedge clk);
        #1;
        check("t3_n_start", 96'(n_start), 96'd3);
        check("t3_sel1_cycles", 96'(n_sel1), 96'd0);
        check("t3_q1_pending", 96'(bus_if.empty_to_acc_1), 96'd0);
        check("t3_idx_idle", 96'(bus_if.tx_queue_idx), 96'd3);
        check_sb_empty("t3");

        // TSF target 1000 with runtime 990 counting up.
        do_reset();
        bus_if.tsf_runtime_val = 64'd990;
        load_pkt(0, 32'hB0, 1, 64'd1000, 64'h500);
        expect_pkt(0, 32'hB0, 1, 64'h500, 1'b1);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            bus_if.tsf_runtime_val = bus_if.tsf_runtime_val + 64'd1;
        end
        wait_done(1, 50, "t4a");
        check("t4_start_after_1000", 96'(start_cyc - t1000_cyc), 96'd1);
        // Target in the past: start right after the wait state.
        bus_if.tsf_runtime_val = 64'd900;
        load_pkt(0, 32'hB1, 1, 64'd5, 64'h600);
        expect_pkt(0, 32'hB1, 1, 64'h600, 1'b1);
        wait_done(2, 50, "t4b");
        check("t4_past_target", 96'(start_cyc - ask_cyc), 96'd2);
        check_sb_empty("t4");

        // N=4, toggling ready, 300 starved cycles after word 2.
        do_reset();
        bus_if.m_ready = 1'b0;
        load_pkt(1, 32'hD0, 4, 64'd0, 64'h700);
        dat_mem[1][xwr[1]] = 64'hDEAD_0001;
        xwr[1]++;
        dat_mem[1][xwr[1]] = 64'hDEAD_0002;
        xwr[1]++;
        expect_pkt(1, 32'hD0, 4, 64'h700, 1'b1);
        begin : t5
            int phase;
            int held;
            int c;
            phase = 0;
            held  = 0;
            c     = 0;
            while (n_done < 1 && c < 1000) begin
                @(posedge clk);
                #1;
                c++;
                bus_if.m_ready = ~bus_if.m_ready;
                if (phase == 0 && n_data >= 2) begin
                    starve = 1'b1;
                    phase  = 1;
                end else if (phase == 1) begin
                    held++;
                    if (held >= 300) begin
                        starve = 1'b0;
                        phase  = 2;
                    end
                end
            end
        end
        repeat (5) @(posedge clk);
        #1;
        check("t5_done", 96'(n_done), 96'd1);
        check("t5_n_data", 96'(n_data), 96'd4);
        check("t5_n_stall", 96'(n_stall), 96'd1);
        check_sb_empty("t5");

        // N=0 descriptor: start and done together, nothing popped from data.
        do_reset();
        load_pkt(2, 32'h77, 0, 64'd0, 64'h0);
        expect_pkt(2, 32'h77, 0, 64'h0, 1'b1);
        wait_done(1, 100, "t6");
        check("t6_n_start", 96'(n_start), 96'd1);
        check("t6_start_with_done", 96'(n_both), 96'd1);
        check("t6_n_data", 96'(n_data), 96'd0);
        check("t6_n_dmg", 96'(n_dmg), 96'd1);
        check_sb_empty("t6");

        // Asynchronous reset in the middle of STREAM.
        do_reset();
        bus_if.m_ready = 1'b0;
        load_pkt(0, 32'hABCD, 4, 64'd0, 64'h800);
        expect_pkt(0, 32'hABCD, 4, 64'h800, 1'b0);
        begin : t7
            int c;
            c = 0;
            while (!bus_if.m_valid && c < 50) begin
                @(posedge clk);
                #1;
                c++;
            end
        end
        check("t7_streaming", 96'(bus_if.m_valid), 96'd1);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("t7_rst_idx", 96'(bus_if.tx_queue_idx), 96'd3);
        check("t7_rst_ctl", {bus_if.acc_ask_dmg, bus_if.acc_ask_tsf, bus_if.acc_ask_data,
                             bus_if.pkt_start, bus_if.pkt_done, bus_if.m_valid,
                             bus_if.m_last, bus_if.err_stall}, 96'd0);
        check("t7_rst_info", {bus_if.pkt_cts_config, bus_if.pkt_num_word}, 96'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
